pio_out_blink_pwm: RTL and testbench
====================================

Name: pio_out_blink_pwm

Overview:
Parametrised Avalon-MM output PIO, the next generation of the team's LED PIO. It drives WIDTH output lines and keeps the atomic set/clear writes of the earlier block. New features:
- atomic toggle writes;
- a per-channel blink mode with a programmable blink period;
- one global PWM brightness control.

It sits on the system interconnect as a zero-wait-state slave and drives board LEDs or other indicator lines.

Parameters:
- WIDTH, 10: number of output channels, 1..32.
- PRESCALE, 50000: clk cycles per blink tick, ≥1.
- CNT_W, 16: width of the blink PERIOD register and blink counter, 1..32.
- PWM_W, 8: width of the PWM counter and DUTY register, 1..16.
- RESET_VALUE, 0: reset value of the DATA register, WIDTH bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data.
- out_port  out  WIDTH  channel outputs.

Behaviour:
- Clock and reset:
  - Clock clk; reset reset_n, asynchronous, active-low.
  - All registers and counters load their reset values immediately when reset_n goes low, including mid-blink or mid-PWM.
- Write strobe: wr = chipselect & ~write_n. Registers change only on a clk edge where wr=1. Writedata bits above each register's width are ignored.
- Register map:
  - 0 DATA, RW, WIDTH bits: load writedata.
  - 1 MODE, RW, WIDTH bits: bit i=1 puts channel i in blink mode.
  - 2 PERIOD, RW, CNT_W bits: blink half-period, in ticks.
  - 3 DUTY, RW, PWM_W bits: brightness.
  - 4 SET, W: DATA |= writedata.
  - 5 CLEAR, W: DATA &= ~writedata.
  - 6 TOGGLE, W: DATA ^= writedata.
  - 7 STATUS, R: bit0 = blink phase; other bits 0.
- Reset values:
  - DATA = RESET_VALUE; MODE = 0; PERIOD = 0.
  - DUTY = all-ones, i.e. full brightness, so the block acts as a plain PIO after reset.
  - Prescaler = 0, blink counter = 0, phase = 1, PWM counter = 0.
  - out_port = RESET_VALUE, registered.
- Reads:
  - Combinational, zero wait states.
  - readdata is the addressed register zero-extended to 32 bits.
  - Addresses 4, 5 and 6 read 0.
  - Reads have no side effects.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 for the single cycle in which it is PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
  - Writes never reset the prescaler.
- Blink counter:
  - On tick, if PERIOD≠0: counter increments. When counter==PERIOD-1, counter←0 and phase toggles.
  - PERIOD==0: counter held at 0 and phase held at 1, so blink channels stay steady on.
  - A write to PERIOD sets counter←0 and phase←1. If it coincides with a tick, the write wins.
  - Resulting full blink cycle: 2·PERIOD·PRESCALE clk cycles.
- PWM:
  - PWM counter free-runs 0..2^PWM_W-1 on every clk and wraps.
  - pwm_on = 1 if DUTY is all-ones, otherwise (pwm_cnt < DUTY).
  - DUTY=0 forces all outputs off.
- Output, per channel i:
  - next_out[i] = DATA[i] & (MODE[i] ? phase : 1) & pwm_on.
  - out_port ← next_out on every clk edge, so one cycle of latency from any register, phase or PWM change.
- Simultaneous events:
  - A register write and a phase toggle in the same cycle both take effect.
  - out_port on the next edge reflects the new DATA/MODE together with the new phase.
  - Only one address is written per cycle, so there are no intra-register conflicts.
- Non-selected bus cycles (chipselect=0) change nothing.

Test Plan:
- Reset check: assert reset_n=0 mid-run with RESET_VALUE=0x2A5 → out_port=0x2A5 immediately; readdata at addr 3 = 0xFF; at addr 7 = 1.
- Atomic writes: write DATA=0x0F0, SET 0x003, CLEAR 0x030, TOGGLE 0x201 → DATA reads 0x0C3 then 0x2C2; out_port follows one cycle after each write.
- Blink timing: PRESCALE=4, MODE=0x001, DATA=0x003, PERIOD=3 → out_port[0] toggles every 12 clk, starting at 1; out_port[1] stays 1; STATUS bit0 tracks out_port[0].
- PWM duty: PWM_W=8, DUTY=64, DATA=0x3FF → out_port=0x3FF for 64 of every 256 cycles. DUTY=0 → out_port=0 constantly. DUTY=255 → out_port constantly 0x3FF.
- Blink boundary and collision:
  - PERIOD=0 → blink channels held on.
  - PERIOD write in the same cycle as a tick → counter=0, phase=1, no toggle.
  - chipselect=0 with write_n=0 → no register change.
- Width check: WIDTH=32 build; write DATA=0xFFFFFFFF then CLEAR 0x80000001 → readdata=0x7FFFFFFE. WIDTH=4 build: bits above bit 3 read 0.

Source files
------------

// File: rtl/pio_out_blink_pwm.sv
// rtl/pio_out_blink_pwm.sv - Avalon-MM output PIO with set/clear/toggle, per-channel blink and global PWM
module pio_out_blink_pwm #(
  parameter int                WIDTH       = 10,
  parameter int                PRESCALE    = 50000,
  parameter int                CNT_W       = 16,
  parameter int                PWM_W       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  // Prescaler counter is at least one bit wide so PRESCALE=1 still builds.
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_DUTY   = 3'd3;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLEAR  = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mode;
  logic [CNT_W-1:0] r_period;
  logic [PWM_W-1:0] r_duty;
  logic [PS_W-1:0]  r_ps;
  logic [CNT_W-1:0] r_bcnt;
  logic             r_phase;
  logic [PWM_W-1:0] r_pwm;

  logic             w_wr;
  logic             w_period_wr;
  logic             w_tick;
  logic             w_pwm_on;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_next_out;
  logic             w_unused_wdata;

  assign w_wr        = chipselect & ~write_n;
  assign w_period_wr = w_wr && (address == ADDR_PERIOD);
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_tick      = (r_ps == PS_LAST);
  // Bits of writedata above a register's width are simply dropped.
  assign w_unused_wdata = ^writedata;

  // DATA register: plain load plus atomic set/clear/toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:   r_data <= w_wd;
        ADDR_SET:    r_data <= r_data | w_wd;
        ADDR_CLEAR:  r_data <= r_data & ~w_wd;
        ADDR_TOGGLE: r_data <= r_data ^ w_wd;
        default:     r_data <= r_data;
      endcase
    end
  end

  // Configuration registers: blink mode mask, blink half-period, PWM duty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode   <= '0;
      r_period <= '0;
      r_duty   <= '1;
    end else if (w_wr) begin
      case (address)
        ADDR_MODE:   r_mode   <= w_wd;
        ADDR_PERIOD: r_period <= writedata[CNT_W-1:0];
        ADDR_DUTY:   r_duty   <= writedata[PWM_W-1:0];
        default:     ;
      endcase
    end
  end

  // Free-running blink prescaler; bus writes never disturb it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ps <= '0;
    end else if (w_tick) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + 1'b1;
    end
  end

  // Blink counter and phase; a PERIOD write restarts the cycle and beats a same-cycle tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (w_period_wr) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (w_tick && (r_period != '0)) begin
      if (r_bcnt == (r_period - 1'b1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt  <= r_bcnt + 1'b1;
      end
    end
  end

  // Free-running PWM counter, wraps at 2^PWM_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  // All-ones duty means always on, so the block behaves as a plain PIO after reset.
  assign w_pwm_on   = (&r_duty) | (r_pwm < r_duty);
  assign w_next_out = r_data & (~r_mode | {WIDTH{r_phase}}) & {WIDTH{w_pwm_on}};

  // Registered outputs: one cycle of latency from any state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else begin
      out_port <= w_next_out;
    end
  end

  // Combinational zero-wait-state read mux; write-only addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(r_data);
      ADDR_MODE:   readdata = 32'(r_mode);
      ADDR_PERIOD: readdata = 32'(r_period);
      ADDR_DUTY:   readdata = 32'(r_duty);
      ADDR_STATUS: readdata[0] = r_phase;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_out_blink_pwm.sv
// tb/tb_pio_out_blink_pwm.sv - directed self-checking bench for pio_out_blink_pwm
module tb_pio_out_blink_pwm;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs, cs32, cs4;
  logic [31:0] rdata, rdata32, rdata4;
  logic [9:0]  outp;
  logic [31:0] outp32;
  logic [3:0]  outp4;

  int vecs = 0;
  int miss = 0;

  pio_out_blink_pwm #(.WIDTH(10), .PRESCALE(4), .CNT_W(16), .PWM_W(8), .RESET_VALUE(10'h2A5)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs), .write_n(write_n),
    .writedata(writedata), .readdata(rdata), .out_port(outp));

  pio_out_blink_pwm #(.WIDTH(32), .PRESCALE(4), .CNT_W(16), .PWM_W(8), .RESET_VALUE(32'h0)) dut32 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32), .write_n(write_n),
    .writedata(writedata), .readdata(rdata32), .out_port(outp32));

  pio_out_blink_pwm #(.WIDTH(4), .PRESCALE(1), .CNT_W(8), .PWM_W(4), .RESET_VALUE(4'h5)) dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs4), .write_n(write_n),
    .writedata(writedata), .readdata(rdata4), .out_port(outp4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sel: 0=dut, 1=dut32, 2=dut4, 3=no chipselect
  task automatic wr(input int sel, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = (sel == 0); cs32 = (sel == 1); cs4 = (sel == 2);
    write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    cs = 1'b0; cs32 = 1'b0; cs4 = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    #1;
  endtask

  initial begin
    int n, on_cnt, off_cnt, bad;
    logic bad1;
    reset_n = 1'b0; cs = 1'b0; cs32 = 1'b0; cs4 = 1'b0;
    write_n = 1'b1; address = '0; writedata = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_out", 32'(outp), 32'h2A5);
    rd(0); chk("rst_data", rdata, 32'h2A5);
    chk("rst_data4", rdata4, 32'h5);
    chk("rst_out32", outp32, 32'h0);
    rd(3); chk("rst_duty", rdata, 32'hFF);
    rd(7); chk("rst_status", rdata, 32'h1);
    rd(2); chk("rst_period", rdata, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // atomic writes with one-cycle output latency
    wr(0, 0, 32'h0F0);
    rd(0); chk("data_load", rdata, 32'h0F0);
    chk("out_latency", 32'(outp), 32'h2A5);
    @(negedge clk); chk("out_after_load", 32'(outp), 32'h0F0);
    wr(0, 4, 32'h003);
    wr(0, 5, 32'h030);
    rd(0); chk("set_clear", rdata, 32'h0C3);
    @(negedge clk); chk("out_set_clear", 32'(outp), 32'h0C3);
    wr(0, 6, 32'h201);
    rd(0); chk("toggle", rdata, 32'h2C2);
    @(negedge clk); chk("out_toggle", 32'(outp), 32'h2C2);
    rd(4); chk("rd_set_zero", rdata, 32'h0);
    rd(5); chk("rd_clear_zero", rdata, 32'h0);
    rd(6); chk("rd_toggle_zero", rdata, 32'h0);
    wr(0, 0, 32'hFFFF_F000);
    rd(0); chk("upper_ignored", rdata, 32'h000);
    wr(3, 0, 32'h3FF);
    rd(0); chk("nocs_data", rdata, 32'h000);
    wr(3, 3, 32'h0);
    rd(3); chk("nocs_duty", rdata, 32'hFF);

    // blink timing: PRESCALE=4, PERIOD=3 -> 12-cycle half period
    wr(0, 1, 32'h001);
    wr(0, 0, 32'h003);
    wr(0, 2, 32'h3);
    rd(2); chk("period_rb", rdata, 32'h3);
    chk("blink_start", 32'(outp), 32'h3);
    rd(7);
    bad1 = 1'b0;
    n = 0;
    while (outp[0] === 1'b1 && n < 20) begin
      @(negedge clk); n++;
      if (outp[1] !== 1'b1) bad1 = 1'b1;
    end
    chk("blink_first_fall", 32'(outp[0]), 32'h0);
    chk("blink_first_window", 32'(n >= 10 && n <= 13), 32'h1);
    chk("status_low", 32'(rdata[0]), 32'h0);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (outp[1] !== 1'b1) bad1 = 1'b1;
    end while (outp[0] === 1'b0 && n < 30);
    chk("blink_low_len", 32'(n), 32'd12);
    chk("status_high", 32'(rdata[0]), 32'h1);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (outp[1] !== 1'b1) bad1 = 1'b1;
    end while (outp[0] === 1'b1 && n < 30);
    chk("blink_high_len", 32'(n), 32'd12);
    chk("status_low2", 32'(rdata[0]), 32'h0);
    chk("steady_ch1", 32'(bad1), 32'h0);

    // PWM duty
    wr(0, 1, 32'h000);
    wr(0, 0, 32'h3FF);
    wr(0, 3, 32'd64);
    rd(3); chk("duty_rb", rdata, 32'd64);
    @(negedge clk);
    on_cnt = 0; off_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (outp === 10'h3FF) on_cnt++;
      if (outp === 10'h000) off_cnt++;
      @(negedge clk);
    end
    chk("pwm64_on", 32'(on_cnt), 32'd64);
    chk("pwm64_off", 32'(off_cnt), 32'd192);
    wr(0, 3, 32'd0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (outp !== 10'h000) bad++;
      @(negedge clk);
    end
    chk("pwm0_off", 32'(bad), 32'd0);
    wr(0, 3, 32'd255);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (outp !== 10'h3FF) bad++;
      @(negedge clk);
    end
    chk("pwm255_on", 32'(bad), 32'd0);

    // PERIOD=0 holds blink channels on
    wr(0, 1, 32'h3FF);
    wr(0, 2, 32'h0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (outp !== 10'h3FF) bad++;
      @(negedge clk);
    end
    chk("period0_hold", 32'(bad), 32'd0);
    rd(7); chk("period0_status", rdata, 32'h1);

    // PERIOD write colliding with a tick: write wins
    wr(0, 2, 32'h1);
    rd(7);
    n = 0;
    while (rdata[0] !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (rdata[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("tick_sync", 32'(rdata[0]), 32'h1);
    repeat (3) @(negedge clk);
    cs = 1'b1; write_n = 1'b0; address = 3'd2; writedata = 32'h2;
    @(negedge clk);
    cs = 1'b0; write_n = 1'b1; writedata = '0;
    rd(7); chk("collide_phase", rdata, 32'h1);
    n = 0;
    while (rdata[0] !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("collide_restart", 32'(n), 32'd8);

    // asynchronous reset mid-run
    rd(0); chk("pre_reset_data", rdata, 32'h3FF);
    @(negedge clk); #1 reset_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(outp), 32'h2A5);
    chk("async_rst_data", rdata, 32'h2A5);
    @(negedge clk);
    rd(3); chk("async_rst_duty", rdata, 32'hFF);
    rd(7); chk("async_rst_status", rdata, 32'h1);
    rd(1); chk("async_rst_mode", rdata, 32'h0);
    rd(2); chk("async_rst_period", rdata, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // width checks
    wr(1, 0, 32'hFFFF_FFFF);
    wr(1, 5, 32'h8000_0001);
    rd(0); chk("w32_data", rdata32, 32'h7FFF_FFFE);
    @(negedge clk); chk("w32_out", outp32, 32'h7FFF_FFFE);
    wr(2, 0, 32'hFFFF_FFFF);
    rd(0); chk("w4_data", rdata4, 32'h0000_000F);
    wr(2, 6, 32'hFFFF_FFF5);
    rd(0); chk("w4_toggle", rdata4, 32'h0000_000A);
    @(negedge clk); chk("w4_out", 32'(outp4), 32'h0000_000A);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
